avg_threshold_detector: RTL and testbench

Downstream consumer of the moving-average filter output. Takes each filtered 8-bit sample, as it is strobed out, and runs hysteresis threshold detection with a consecutive-sample qualification counter. It produces a level alarm, one-cycle rise/fall event pulses, a saturating event counter and the peak filtered value of the current/last alarm episode. These outputs drive the uo_out/uio_out status pins at top level.

---
 rtl/avg_threshold_detector.sv | 171 +++++++++++++++++
 tb/tb_avg_threshold_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_threshold_detector.sv
// Hysteresis threshold detector on strobed filtered samples: qualified alarm level,
// rise/fall event pulses, saturating rise counter and per-episode peak capture.
module avg_threshold_detector #(
    parameter int DATA_W   = 8,
    parameter int HOLD_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic              clear_cnt,
    output logic              alarm,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [DATA_W-1:0] peak
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_ARM_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_ARM_LO = 2'd3
    } state_t;

    localparam logic [3:0]       HOLD_V  = 4'(HOLD_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r, state_nxt_s;
    logic [3:0]        qual_r, qual_nxt_s;
    logic              alarm_r, rise_r, fall_r;
    logic              rise_s, fall_s;
    logic [CNT_W-1:0]  event_cnt_r, cnt_base_s, cnt_nxt_s;
    logic [DATA_W-1:0] peak_r, peak_nxt_s;
    logic [DATA_W-1:0] eff_lo_s;
    logic              hi_q_s, lo_q_s;

    // Sample qualification; an inverted threshold pair collapses the low threshold onto thr_hi
    always_comb begin
        if (thr_lo < thr_hi) begin
            eff_lo_s = thr_lo;
        end else begin
            eff_lo_s = thr_hi;
        end
        hi_q_s = (in_data > thr_hi);
        lo_q_s = (in_data < eff_lo_s);
    end

    // Next-state logic and event detection, advanced only by valid samples
    always_comb begin
        state_nxt_s = state_r;
        qual_nxt_s  = qual_r;
        rise_s      = 1'b0;
        fall_s      = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_LOW: begin
                    if (hi_q_s) begin
                        if (HOLD_V == 4'd1) begin
                            state_nxt_s = ST_HIGH;
                            qual_nxt_s  = 4'd0;
                            rise_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARM_HI;
                            qual_nxt_s  = 4'd1;
                        end
                    end else begin
                        qual_nxt_s = 4'd0;
                    end
                end
                ST_ARM_HI: begin
                    if (!hi_q_s) begin
                        state_nxt_s = ST_LOW;
                        qual_nxt_s  = 4'd0;
                    end else if (qual_r + 4'd1 == HOLD_V) begin
                        state_nxt_s = ST_HIGH;
                        qual_nxt_s  = 4'd0;
                        rise_s      = 1'b1;
                    end else begin
                        qual_nxt_s = qual_r + 4'd1;
                    end
                end
                ST_HIGH: begin
                    if (lo_q_s) begin
                        if (HOLD_V == 4'd1) begin
                            state_nxt_s = ST_LOW;
                            qual_nxt_s  = 4'd0;
                            fall_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARM_LO;
                            qual_nxt_s  = 4'd1;
                        end
                    end else begin
                        qual_nxt_s = 4'd0;
                    end
                end
                ST_ARM_LO: begin
                    if (!lo_q_s) begin
                        state_nxt_s = ST_HIGH;
                        qual_nxt_s  = 4'd0;
                    end else if (qual_r + 4'd1 == HOLD_V) begin
                        state_nxt_s = ST_LOW;
                        qual_nxt_s  = 4'd0;
                        fall_s      = 1'b1;
                    end else begin
                        qual_nxt_s = qual_r + 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_LOW;
                    qual_nxt_s  = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Event counter (clear applied before the increment) and episode peak tracking
    always_comb begin
        if (clear_cnt) begin
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            cnt_base_s = event_cnt_r;
        end
        if (rise_s && (cnt_base_s != CNT_MAX)) begin
            cnt_nxt_s = cnt_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_base_s;
        end
        if (rise_s) begin
            peak_nxt_s = in_data;
        end else if (in_valid && ((state_r == ST_HIGH) || (state_r == ST_ARM_LO))
                     && (in_data > peak_r)) begin
            peak_nxt_s = in_data;
        end else begin
            peak_nxt_s = peak_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOW;
            qual_r      <= 4'd0;
            alarm_r     <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            event_cnt_r <= {CNT_W{1'b0}};
            peak_r      <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            qual_r      <= qual_nxt_s;
            alarm_r     <= (state_nxt_s == ST_HIGH) || (state_nxt_s == ST_ARM_LO);
            rise_r      <= rise_s;
            fall_r      <= fall_s;
            event_cnt_r <= cnt_nxt_s;
            peak_r      <= peak_nxt_s;
        end
    end

    assign alarm      = alarm_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign event_cnt  = event_cnt_r;
    assign peak       = peak_r;

endmodule

// File: tb/tb_avg_threshold_detector.sv
// Bench for avg_threshold_detector: two parameterisations driven with shared stimulus,
// checked against constant vectors and a run-length reference model.
module tb_avg_threshold_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic [7:0] thr_hi = 8'd100;
    logic [7:0] thr_lo = 8'd60;
    logic       clear_cnt = 1'b0;

    logic       a_alarm, a_rise, a_fall;
    logic [7:0] a_cnt, a_peak;
    logic       b_alarm, b_rise, b_fall;
    logic [1:0] b_cnt;
    logic [7:0] b_peak;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avg_threshold_detector #(.DATA_W(8), .HOLD_CNT(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear_cnt(clear_cnt),
        .alarm(a_alarm), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .event_cnt(a_cnt), .peak(a_peak));

    avg_threshold_detector #(.DATA_W(8), .HOLD_CNT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .clear_cnt(clear_cnt),
        .alarm(b_alarm), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .event_cnt(b_cnt), .peak(b_peak));

    // Reference: alarm level plus length of the current run of opposite-side samples
    typedef struct {
        bit alarm;
        int run;
        int cnt;
        int peak;
        bit rise;
        bit fall;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, int hold, int cmax, bit r, bit v,
                                  int d, int hi, int lo, bit clr);
        mdl_t n;
        int   elo;
        n = m;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (r) begin
            n.alarm = 1'b0; n.run = 0; n.cnt = 0; n.peak = 0;
            return n;
        end
        if (clr) n.cnt = 0;
        if (!v) return n;
        elo = (lo < hi) ? lo : hi;
        if (!m.alarm) begin
            n.run = (d > hi) ? m.run + 1 : 0;
            if (n.run == hold) begin
                n.alarm = 1'b1; n.run = 0; n.rise = 1'b1; n.peak = d;
                if (n.cnt < cmax) n.cnt = n.cnt + 1;
            end
        end else begin
            if (d > n.peak) n.peak = d;
            n.run = (d < elo) ? m.run + 1 : 0;
            if (n.run == hold) begin
                n.alarm = 1'b0; n.run = 0; n.fall = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        check("a_alarm", 32'(a_alarm), 32'(ma.alarm));
        check("a_rise",  32'(a_rise),  32'(ma.rise));
        check("a_fall",  32'(a_fall),  32'(ma.fall));
        check("a_cnt",   32'(a_cnt),   32'(ma.cnt));
        check("a_peak",  32'(a_peak),  32'(ma.peak));
        check("b_alarm", 32'(b_alarm), 32'(mb.alarm));
        check("b_rise",  32'(b_rise),  32'(mb.rise));
        check("b_fall",  32'(b_fall),  32'(mb.fall));
        check("b_cnt",   32'(b_cnt),   32'(mb.cnt));
        check("b_peak",  32'(b_peak),  32'(mb.peak));
    endtask

    task automatic apply(bit r, bit v, int d, int hi, int lo, bit c);
        rst       = r;
        in_valid  = v;
        in_data   = 8'(d);
        thr_hi    = 8'(hi);
        thr_lo    = 8'(lo);
        clear_cnt = c;
        @(posedge clk);
        #1;
        ma = step(ma, 4, 255, r, v, d, hi, lo, c);
        mb = step(mb, 1, 3,   r, v, d, hi, lo, c);
        check_models();
    endtask

    typedef struct {
        bit v; int d; int hi; int lo; bit c;
        bit e_alarm; bit e_rise; bit e_fall; int e_cnt; int e_peak;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit v, int d, int hi, int lo, bit c,
                       bit ea, bit er, bit ef, int ec, int ep);
        vec_t x;
        x.v = v; x.d = d; x.hi = hi; x.lo = lo; x.c = c;
        x.e_alarm = ea; x.e_rise = er; x.e_fall = ef; x.e_cnt = ec; x.e_peak = ep;
        vecs.push_back(x);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].v, vecs[i].d, vecs[i].hi, vecs[i].lo, vecs[i].c);
            check("vec_alarm", 32'(a_alarm), 32'(vecs[i].e_alarm));
            check("vec_rise",  32'(a_rise),  32'(vecs[i].e_rise));
            check("vec_fall",  32'(a_fall),  32'(vecs[i].e_fall));
            check("vec_cnt",   32'(a_cnt),   32'(vecs[i].e_cnt));
            check("vec_peak",  32'(a_peak),  32'(vecs[i].e_peak));
        end
        vecs.delete();
    endtask

    initial begin
        int  hi, lo, elo, d;
        bit  phase, v, c, r;

        ma = '{default: 0};
        mb = '{default: 0};

        // Reset state
        apply(1'b1, 1'b1, 200, 100, 60, 1'b0);
        check("reset_alarm", 32'(a_alarm), 32'd0);
        check("reset_cnt",   32'(a_cnt),   32'd0);
        check("reset_peak",  32'(a_peak),  32'd0);

        // Rise qualification, gap cycle, fall, abort and threshold boundaries (HOLD_CNT=4)
        for (int i = 0; i < 3; i++) add(1, 120, 100, 60, 0, 0, 0, 0, 0, 0);
        add(1, 120, 100, 60, 0, 1, 1, 0, 1, 120);
        add(0, 0,   100, 60, 0, 1, 0, 0, 1, 120);
        for (int i = 0; i < 3; i++) add(1, 59, 100, 60, 0, 1, 0, 0, 1, 120);
        add(1, 59,  100, 60, 0, 0, 0, 1, 1, 120);
        add(0, 59,  100, 60, 0, 0, 0, 0, 1, 120);
        for (int i = 0; i < 3; i++) add(1, 120, 100, 60, 0, 0, 0, 0, 1, 120);
        add(1, 100, 100, 60, 0, 0, 0, 0, 1, 120);
        for (int i = 0; i < 3; i++) add(1, 101, 100, 60, 0, 0, 0, 0, 1, 120);
        add(1, 101, 100, 60, 0, 1, 1, 0, 2, 101);
        for (int i = 0; i < 4; i++) add(1, 60, 100, 60, 0, 1, 0, 0, 2, 101);
        for (int i = 0; i < 3; i++) add(1, 59, 100, 60, 0, 1, 0, 0, 2, 101);
        add(1, 59,  100, 60, 0, 0, 0, 1, 2, 101);
        run_vecs();

        // Peak tracking across invalid gaps, then held after the fall
        for (int i = 0; i < 4; i++) apply(0, 1, 120, 100, 60, 0);
        check("peak_rise", 32'(a_peak), 32'd120);
        apply(0, 1, 130, 100, 60, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 250, 100, 60, 0);
        check("peak_gap", 32'(a_peak), 32'd130);
        apply(0, 1, 200, 100, 60, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 10, 100, 60, 0);
        apply(0, 1, 90, 100, 60, 0);
        check("peak_max", 32'(a_peak), 32'd200);
        for (int i = 0; i < 4; i++) apply(0, 1, 59, 100, 60, 0);
        check("peak_fall_alarm", 32'(a_alarm), 32'd0);
        for (int i = 0; i < 3; i++) apply(0, 1, 90, 100, 60, 0);
        check("peak_held", 32'(a_peak), 32'd200);

        // Inverted thresholds: effective low threshold becomes thr_hi
        for (int i = 0; i < 4; i++) apply(0, 1, 120, 50, 80, 0);
        apply(0, 1, 60, 50, 80, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 40, 50, 80, 0);
        check("inv_no_arm", 32'(a_alarm), 32'd1);
        apply(0, 1, 40, 50, 80, 0);
        check("inv_fall", 32'(a_fall), 32'd1);
        check("inv_alarm", 32'(a_alarm), 32'd0);

        // Reset while arming toward LOW
        for (int i = 0; i < 4; i++) apply(0, 1, 120, 100, 60, 0);
        apply(0, 1, 59, 100, 60, 0);
        apply(0, 1, 59, 100, 60, 0);
        apply(1, 1, 59, 100, 60, 0);
        check("rst_mid_alarm", 32'(a_alarm), 32'd0);
        check("rst_mid_cnt",   32'(a_cnt),   32'd0);
        check("rst_mid_peak",  32'(a_peak),  32'd0);
        for (int i = 0; i < 3; i++) apply(0, 1, 120, 100, 60, 0);
        check("rst_requal", 32'(a_alarm), 32'd0);
        apply(0, 1, 120, 100, 60, 0);
        check("rst_rise", 32'(a_rise), 32'd1);

        // Saturating 2-bit counter (HOLD_CNT=1 instance), then clear with a rise
        apply(1, 0, 0, 100, 60, 0);
        for (int k = 1; k <= 4; k++) begin
            apply(0, 1, 120, 100, 60, 0);
            check("sat_cnt", 32'(b_cnt), 32'(k > 3 ? 3 : k));
            apply(0, 1, 59, 100, 60, 0);
        end
        apply(0, 1, 120, 100, 60, 1);
        check("clr_rise_cnt", 32'(b_cnt), 32'd1);
        apply(0, 0, 0, 100, 60, 1);
        check("clr_idle_cnt", 32'(b_cnt), 32'd0);

        // Randomised run against the reference model
        hi = 100; lo = 60; phase = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                hi = $urandom_range(0, 255);
                lo = $urandom_range(0, 255);
            end
            if ($urandom_range(0, 11) == 0) phase = ~phase;
            elo = (lo < hi) ? lo : hi;
            case ($urandom_range(0, 9))
                0:       d = $urandom_range(0, 255);
                1:       d = ($urandom_range(0, 1) == 1) ? hi : elo;
                default: begin
                    if (phase) d = (hi < 255) ? $urandom_range(hi + 1, 255) : 255;
                    else       d = (elo > 0) ? $urandom_range(0, elo - 1) : 0;
                end
            endcase
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 599) == 0);
            apply(r, v, d, hi, lo, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
